// File: rtl/adc_read_capture.sv
// ADC read-side capture: waits for INTR_N after DONE, strobes RD low, latches DB.
// Define ADC_READ_AVG_EN to enable 2^AVG_LOG2 block averaging on o_avg/o_avg_valid.
module adc_read_capture #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned RD_SETTLE    = 4,
    parameter int unsigned INTR_TIMEOUT = 255,
    parameter int unsigned AVG_LOG2     = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_done,
    input  logic              i_intr_n,
    input  logic [DATA_W-1:0] i_db,
    output logic              o_rd,
    output logic [DATA_W-1:0] o_sample,
    output logic              o_sample_valid,
    output logic [DATA_W-1:0] o_avg,
    output logic              o_avg_valid,
    output logic              o_busy,
    output logic              o_timeout_err
);

    localparam int unsigned TO_W = (INTR_TIMEOUT > 1) ? $clog2(INTR_TIMEOUT) : 1;
    localparam int unsigned ST_W = (RD_SETTLE > 1) ? $clog2(RD_SETTLE) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(INTR_TIMEOUT - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(RD_SETTLE - 1);

    if (RD_SETTLE < 1 || INTR_TIMEOUT < 1 || AVG_LOG2 >= 32) begin : g_bad_cfg
        $error("adc_read_capture: illegal parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT_INTR, S_READ, S_RECOVER} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [TO_W-1:0]   r_to_cnt;
    logic [TO_W-1:0]   w_to_cnt_next;
    logic [ST_W-1:0]   r_st_cnt;
    logic [ST_W-1:0]   w_st_cnt_next;
    logic              r_intr_meta;
    logic              r_intr_s;
    logic              r_rd;
    logic              w_rd_next;
    logic              w_capture;
    logic              w_timeout;
    logic [DATA_W-1:0] r_sample;
    logic              r_sample_valid;
    logic              r_timeout_err;

    // INTR_N is asynchronous to i_clk; only the second flop is ever looked at.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_intr_meta <= 1'b1;
            r_intr_s    <= 1'b1;
        end else begin
            r_intr_meta <= i_intr_n;
            r_intr_s    <= r_intr_meta;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_to_cnt_next = r_to_cnt;
        w_st_cnt_next = r_st_cnt;
        w_rd_next     = 1'b1;
        w_capture     = 1'b0;
        w_timeout     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_done) begin
                    w_state_next  = S_WAIT_INTR;
                    w_to_cnt_next = '0;
                end
            end
            S_WAIT_INTR: begin
                // INTR beats the timeout when both land on the same cycle
                if (!r_intr_s) begin
                    w_state_next  = S_READ;
                    w_rd_next     = 1'b0;
                    w_st_cnt_next = '0;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_next = S_IDLE;
                    w_timeout    = 1'b1;
                end else begin
                    w_to_cnt_next = r_to_cnt + TO_W'(1);
                end
            end
            S_READ: begin
                if (r_st_cnt == ST_LAST) begin
                    w_state_next = S_RECOVER;
                    w_capture    = 1'b1;
                end else begin
                    w_rd_next     = 1'b0;
                    w_st_cnt_next = r_st_cnt + ST_W'(1);
                end
            end
            S_RECOVER: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_to_cnt       <= '0;
            r_st_cnt       <= '0;
            r_rd           <= 1'b1;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_to_cnt       <= w_to_cnt_next;
            r_st_cnt       <= w_st_cnt_next;
            r_rd           <= w_rd_next;
            r_sample_valid <= w_capture;
            r_timeout_err  <= w_timeout;
            if (w_capture) begin
                r_sample <= i_db;
            end
        end
    end

    assign o_rd           = r_rd;
    assign o_sample       = r_sample;
    assign o_sample_valid = r_sample_valid;
    assign o_busy         = (r_state != S_IDLE);
    assign o_timeout_err  = r_timeout_err;

`ifdef ADC_READ_AVG_EN
    localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
    localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'((64'd1 << AVG_LOG2) - 64'd1);

    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  w_acc_sum;
    logic [CNT_W-1:0]  r_blk_cnt;
    logic [DATA_W-1:0] r_avg;
    logic              r_avg_valid;

    assign w_acc_sum = r_acc + ACC_W'(r_sample);

    // The last sample of a block is folded in directly so AVG follows one edge after it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc       <= '0;
            r_blk_cnt   <= '0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_avg_valid <= 1'b0;
            if (r_sample_valid) begin
                if (r_blk_cnt == BLK_LAST) begin
                    r_avg       <= DATA_W'(w_acc_sum >> AVG_LOG2);
                    r_avg_valid <= 1'b1;
                    r_acc       <= '0;
                    r_blk_cnt   <= '0;
                end else begin
                    r_acc     <= w_acc_sum;
                    r_blk_cnt <= r_blk_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_avg       = r_avg;
    assign o_avg_valid = r_avg_valid;
`else
    assign o_avg       = '0;
    assign o_avg_valid = 1'b0;
`endif

endmodule

// File: tb/tb_adc_read_capture.sv
// Directed bench for adc_read_capture (RD_SETTLE=4, INTR_TIMEOUT=16, AVG_LOG2=2).
module tb_adc_read_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       done;
    logic       intr_n;
    logic [7:0] db;
    logic       rd;
    logic [7:0] sample;
    logic       sample_valid;
    logic [7:0] avg;
    logic       avg_valid;
    logic       busy;
    logic       timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_avg_pulses = 0;

    always #5 clk = ~clk;

    adc_read_capture #(
        .DATA_W      (8),
        .RD_SETTLE   (4),
        .INTR_TIMEOUT(16),
        .AVG_LOG2    (2)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_done        (done),
        .i_intr_n      (intr_n),
        .i_db          (db),
        .o_rd          (rd),
        .o_sample      (sample),
        .o_sample_valid(sample_valid),
        .o_avg         (avg),
        .o_avg_valid   (avg_valid),
        .o_busy        (busy),
        .o_timeout_err (timeout_err)
    );

    always @(negedge clk) begin
        if (avg_valid === 1'b1) n_avg_pulses <= n_avg_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full DONE -> INTR -> RD -> capture sequence with edge-exact checks.
    task automatic read_sample(input string tag, input logic [7:0] d,
                               input logic exp_av, input logic [7:0] exp_avg);
        db   = d;
        done = 1'b1;
        tick();
        done   = 1'b0;
        intr_n = 1'b0;
        check({tag, "_busy_wait"}, 32'(busy), 32'd1);
        tick();
        tick();
        check({tag, "_rd_before"}, 32'(rd), 32'd1);
        tick();
        check({tag, "_rd_low"}, 32'(rd), 32'd0);
        intr_n = 1'b1;
        tick();
        tick();
        tick();
        check({tag, "_rd_still_low"}, 32'(rd), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(sample_valid), 32'd1);
        check({tag, "_sample"}, 32'(sample), 32'(d));
        tick();
        check({tag, "_idle"}, 32'(busy), 32'd0);
`ifdef ADC_READ_AVG_EN
        check({tag, "_avg_valid"}, 32'(avg_valid), 32'(exp_av));
        if (exp_av) check({tag, "_avg"}, 32'(avg), 32'(exp_avg));
`endif
    endtask

    initial begin
        int bad;
        rst    = 1'b1;
        done   = 1'b0;
        intr_n = 1'b1;
        db     = 8'h00;
        tick();
        tick();
        tick();
        check("rst_rd", 32'(rd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_outs", 32'({sample_valid, avg_valid, timeout_err, avg}), 32'd0);
        rst = 1'b0;

        // INTR_N activity without DONE must not start a read
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            intr_n = ~intr_n;
            tick();
            if (rd !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("idle_intr_ignored", 32'(bad), 32'd0);
        intr_n = 1'b1;
        tick();
        tick();
        tick();

        // Nominal read, INTR_N falls 5 cycles after DONE
        db   = 8'hA5;
        done = 1'b1;
        tick();
        done = 1'b0;
        check("nom_busy", 32'(busy), 32'd1);
        tick();
        tick();
        tick();
        tick();
        intr_n = 1'b0;
        tick();
        check("nom_rd_e1", 32'(rd), 32'd1);
        tick();
        check("nom_rd_e2", 32'(rd), 32'd1);
        tick();
        check("nom_rd_e3", 32'(rd), 32'd0);
        intr_n = 1'b1;
        bad    = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rd !== 1'b0 || sample_valid !== 1'b0) bad++;
        end
        check("nom_rd_hold", 32'(bad), 32'd0);
        tick();
        check("nom_rd_high", 32'(rd), 32'd1);
        check("nom_valid", 32'(sample_valid), 32'd1);
        check("nom_sample", 32'(sample), 32'hA5);
        check("nom_busy_recover", 32'(busy), 32'd1);
        tick();
        check("nom_valid_pulse", 32'(sample_valid), 32'd0);
        check("nom_busy_drop", 32'(busy), 32'd0);

        // Timeout with INTR_N held high
        done = 1'b1;
        tick();
        done = 1'b0;
        bad  = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (timeout_err !== 1'b0 || rd !== 1'b1 || busy !== 1'b1) bad++;
        end
        check("to_early", 32'(bad), 32'd0);
        tick();
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_idle", 32'(busy), 32'd0);
        tick();
        check("to_err_pulse", 32'(timeout_err), 32'd0);
        check("to_sample_kept", 32'(sample), 32'hA5);

        // DONE during READ and during the RECOVER->IDLE edge is dropped
        db   = 8'h3C;
        done = 1'b1;
        tick();
        done   = 1'b0;
        intr_n = 1'b0;
        tick();
        tick();
        tick();
        check("db_rd_low", 32'(rd), 32'd0);
        intr_n = 1'b1;
        done   = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        tick();
        check("db_valid", 32'(sample_valid), 32'd1);
        check("db_sample", 32'(sample), 32'h3C);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("db_recover_done", 32'(busy), 32'd0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy !== 1'b0 || sample_valid !== 1'b0 || rd !== 1'b1) bad++;
        end
        check("db_no_second", 32'(bad), 32'd0);

        // Reset two cycles into READ
        db   = 8'h77;
        done = 1'b1;
        tick();
        done   = 1'b0;
        intr_n = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("mr_in_read", 32'(rd), 32'd0);
        rst    = 1'b1;
        intr_n = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_rd", 32'(rd), 32'd1);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_sample", 32'(sample), 32'd0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (sample_valid !== 1'b0) bad++;
        end
        check("mr_no_valid", 32'(bad), 32'd0);
        read_sample("mr_after", 8'h5A, 1'b0, 8'h00);

        // Fresh block: 10,20,30,41 averages to 25
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        read_sample("avg1", 8'd10, 1'b0, 8'd0);
        read_sample("avg2", 8'd20, 1'b0, 8'd0);
        read_sample("avg3", 8'd30, 1'b0, 8'd0);
        read_sample("avg4", 8'd41, 1'b1, 8'd25);
        tick();
`ifdef ADC_READ_AVG_EN
        check("avg_pulse_count", 32'(n_avg_pulses), 32'd1);
        check("avg_hold", 32'(avg), 32'd25);
`else
        check("avg_never_valid", 32'(n_avg_pulses), 32'd0);
        check("avg_zero", 32'(avg), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
